// File: rtl/axis_gpio_pkg.sv
// Shared types and constants for the AXI4-Stream GPIO reader/writer blocks.
package axis_gpio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Stream word layout: output value in the low half, output enable in the high half.
  localparam int TDATA_VAL_LSB = 0;
  localparam int SYNC_DEPTH    = 2;

  function automatic int tdata_oe_lsb(input int w);
    return w;
  endfunction

endpackage

// File: rtl/axis_gpio_writer_if.sv
// AXI4-Stream channel carrying one GPIO update (value and output-enable halves).
interface axis_gpio_writer_if #(
  parameter int W = 32
);

  logic [2*W-1:0] tdata;
  logic           tvalid;
  logic           tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/gpio_pad_bank.sv
// Bank of W bidirectional pad buffers with IOBUF semantics: T=1 releases the pad.
module gpio_pad_bank #(
  parameter int W = 32
) (
  input  logic [W-1:0] I,
  input  logic [W-1:0] T,
  output logic [W-1:0] O,
  inout  wire  [W-1:0] IO
);

  for (genvar gi = 0; gi < W; gi++) begin : g_iobuf
    assign IO[gi] = T[gi] ? 1'bz : I[gi];
    assign O[gi]  = IO[gi];
  end

endmodule

// File: rtl/axis_gpio_writer.sv
// AXI4-Stream slave driving a tristate GPIO bank, each word held for at least cfg_hold+1 cycles.
// Define AXIS_GPIO_WRITER_READBACK_EN to add a synchronized pin readback pulse at the end of each hold.
module axis_gpio_writer
  import axis_gpio_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_hold,
  axis_gpio_writer_if.slave           s_axis,
  inout  wire  [AXIS_TDATA_WIDTH-1:0] gpio_data,
`ifdef AXIS_GPIO_WRITER_READBACK_EN
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
`endif
  output logic                        sts_busy
);

  localparam int W       = AXIS_TDATA_WIDTH;
  localparam int VAL_LSB = TDATA_VAL_LSB;
  localparam int OE_LSB  = tdata_oe_lsb(AXIS_TDATA_WIDTH);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_HOLD = HOLD;

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  logic [0:0]            state_reg;
  logic [0:0]            state_next;
  logic [CNTR_WIDTH-1:0] cnt_reg;
  logic [CNTR_WIDTH-1:0] cnt_next;
  logic                  ready_reg;
  logic [W-1:0]          out_reg;
  logic [W-1:0]          out_next;
  logic [W-1:0]          oe_reg;
  logic [W-1:0]          oe_next;
  logic                  tready;
  logic                  accept;
  logic                  hold_exit;
  logic [W-1:0]          pad_t;

  assign tready        = ready_reg & (state_reg == ST_IDLE);
  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid & tready;
  assign hold_exit     = (state_reg == ST_HOLD) && (cnt_reg == CNT_ONE);
  assign sts_busy      = (state_reg == ST_HOLD);

  // The counter stops at 1 rather than 0, so a full-scale hold never wraps.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    oe_next    = oe_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          out_next = s_axis.tdata[VAL_LSB +: W];
          oe_next  = s_axis.tdata[OE_LSB +: W];
          if (cfg_hold != '0) begin
            state_next = ST_HOLD;
            cnt_next   = cfg_hold;
          end
        end
      end
      ST_HOLD: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (hold_exit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      out_reg   <= '0;
      oe_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= 1'b1;
      out_reg   <= out_next;
      oe_reg    <= oe_next;
    end
  end

  assign pad_t = ~oe_reg;

`ifdef AXIS_GPIO_WRITER_READBACK_EN
  logic [W-1:0]                 pad_o;
  logic [SYNC_DEPTH-1:0][W-1:0] sync_reg;

  gpio_pad_bank #(.W(W)) u_pads (
    .I  (out_reg),
    .T  (pad_t),
    .O  (pad_o),
    .IO (gpio_data)
  );

  // Pads are asynchronous to aclk; the last stage is what the pulse reports.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_reg      <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_DEPTH-2:0], pad_o};
      m_axis_tvalid <= hold_exit;
      if (hold_exit) begin
        m_axis_tdata <= sync_reg[SYNC_DEPTH-1];
      end
    end
  end
`else
  logic [W-1:0] pad_o_unused;

  gpio_pad_bank #(.W(W)) u_pads (
    .I  (out_reg),
    .T  (pad_t),
    .O  (pad_o_unused),
    .IO (gpio_data)
  );
`endif

endmodule

// File: tb/tb_axis_gpio_writer.sv
// Randomized bench for axis_gpio_writer against a timestamp-based behavioural model.
// Readback checks are compiled in when AXIS_GPIO_WRITER_READBACK_EN is defined.
module tb_axis_gpio_writer;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] cfg_hold;
  wire  [W-1:0]  gpio_data;
  logic          sts_busy;
  logic [W-1:0]  ext_val;
  logic [W-1:0]  ext_en;
  logic          cmp_en;
  int            errors = 0;
  int            checks = 0;
`ifdef AXIS_GPIO_WRITER_READBACK_EN
  logic [W-1:0]  m_axis_tdata;
  logic          m_axis_tvalid;
`endif

  axis_gpio_writer_if #(.W(W)) s_if();

  axis_gpio_writer #(
    .AXIS_TDATA_WIDTH (W),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_hold      (cfg_hold),
    .s_axis        (s_if),
    .gpio_data     (gpio_data),
`ifdef AXIS_GPIO_WRITER_READBACK_EN
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
`endif
    .sts_busy      (sts_busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- behavioural model ----------------
  // m_n counts edges since reset; next accept is allowed from edge m_next_ok on.
  logic         m_ready;
  logic [W-1:0] m_out;
  logic [W-1:0] m_oe;
  int           m_n;
  int           m_next_ok;
  int           rb_edge;
  int           rb_hold;
  logic         exp_tready;
  logic         exp_busy;
  logic [W-1:0] exp_pins;
  logic         exp_rbv;

  assign exp_tready = m_ready && (m_n + 1 >= m_next_ok);
  assign exp_busy   = m_ready && !(m_n + 1 >= m_next_ok);
  assign exp_pins   = (m_out & m_oe) | (ext_val & ~m_oe);
  assign exp_rbv    = (m_n == rb_edge);

  // External driver only on bits the DUT should be leaving high-Z.
  assign ext_en = ~m_oe;
  for (genvar gi = 0; gi < W; gi++) begin : g_ext
    assign gpio_data[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_ready   <= 1'b0;
      m_out     <= '0;
      m_oe      <= '0;
      m_n       <= 0;
      m_next_ok <= 0;
      rb_edge   <= -1;
      rb_hold   <= 0;
    end else begin
      m_n     <= m_n + 1;
      m_ready <= 1'b1;
      if (s_if.tvalid && exp_tready) begin
        m_out     <= s_if.tdata[W-1:0];
        m_oe      <= s_if.tdata[2*W-1:W];
        m_next_ok <= m_n + 2 + int'(cfg_hold);
        if (cfg_hold != '0) begin
          rb_edge <= m_n + 1 + int'(cfg_hold);
          rb_hold <= int'(cfg_hold);
        end
        $display("t=%0t accept oe=%h val=%h hold=%0d", $time, s_if.tdata[2*W-1:W],
                 s_if.tdata[W-1:0], cfg_hold);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge aclk) begin
    if (cmp_en) begin
      chk("tready", 32'(s_if.tready), 32'(exp_tready));
      chk("busy", 32'(sts_busy), 32'(exp_busy));
      chk("pins", 32'(gpio_data), 32'(exp_pins));
`ifdef AXIS_GPIO_WRITER_READBACK_EN
      chk("rb_valid", 32'(m_axis_tvalid), 32'(exp_rbv));
      if (exp_rbv && rb_hold >= 3) chk("rb_data", 32'(m_axis_tdata), 32'(exp_pins));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!s_if.tready && n < 100) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(s_if.tready), 32'd1);
  endtask

  task automatic measure_low(input logic [W-1:0] v, output int low, output int held);
    low  = 0;
    held = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (gpio_data == v) held++;
      if (s_if.tready) break;
      low++;
    end
  endtask

  initial begin
    int low;
    int held;
    int pulses;
    logic [W-1:0] rb_data;
    aresetn     = 1'b1;
    cmp_en      = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    cfg_hold    = '0;
    ext_val     = 8'h3C;
    #1 aresetn  = 1'b0;
    #1 cmp_en   = 1'b1;

    // Reset: all pins released, not ready.
    repeat (3) step();
    @(negedge aclk);
    chk("rst_tready", 32'(s_if.tready), 32'd0);
    chk("rst_pins_z", 32'(gpio_data), 32'h3C);
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_tready_pre", 32'(s_if.tready), 32'd0);
    step();
    chk("rel_tready", 32'(s_if.tready), 32'd1);

    // Back-to-back words with zero hold.
    ext_val     = 8'h00;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'hFF, 8'hA5};
    step();
    s_if.tdata  = {8'h0F, 8'h3C};
    @(negedge aclk);
    chk("b2b_pins1", 32'(gpio_data), 32'hA5);
    chk("b2b_tready1", 32'(s_if.tready), 32'd1);
    step();
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("b2b_pins2", 32'(gpio_data), 32'h0C);
    chk("b2b_tready2", 32'(s_if.tready), 32'd1);

    // Hold of 3 with valid held high.
    step();
    cfg_hold    = 16'd3;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'hFF, 8'h11};
    step();
    s_if.tdata  = {8'hFF, 8'h22};
    measure_low(8'h11, low, held);
    chk("hold3_low", 32'(low), 32'd3);
    chk("hold3_spacing", 32'(low + 1), 32'd4);
    chk("hold3_held", 32'(held), 32'd4);
    step();
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("hold3_pins2", 32'(gpio_data), 32'h22);

    // cfg_hold change during HOLD affects only the next word.
    wait_idle();
    cfg_hold    = 16'd5;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'hFF, 8'h33};
    step();
    cfg_hold    = 16'd1;
    s_if.tdata  = {8'hFF, 8'h44};
    measure_low(8'h33, low, held);
    chk("chg_low5", 32'(low), 32'd5);
    step();
    s_if.tvalid = 1'b0;
    measure_low(8'h44, low, held);
    chk("chg_low1", 32'(low), 32'd1);

    // Reset in the middle of a hold.
    wait_idle();
    cfg_hold    = 16'd6;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'hFF, 8'h77};
    step();
    s_if.tvalid = 1'b0;
    repeat (3) step();
    chk("midhold_busy", 32'(sts_busy), 32'd1);
    aresetn = 1'b0;
    ext_val = 8'h96;
    #1;
    chk("midrst_pins_z", 32'(gpio_data), 32'h96);
    chk("midrst_busy", 32'(sts_busy), 32'd0);
    chk("midrst_tready", 32'(s_if.tready), 32'd0);
    step();
    aresetn = 1'b1;
    step();
    cfg_hold    = 16'd0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'h0F, 8'h5B};
    step();
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    chk("post_rst_pins", 32'(gpio_data), 32'h9B);

    // Randomized traffic.
    step();
    for (int i = 0; i < 400; i++) begin
      s_if.tvalid = ($urandom_range(0, 2) != 0);
      s_if.tdata  = 16'($urandom);
      cfg_hold    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 5));
`ifndef AXIS_GPIO_WRITER_READBACK_EN
      ext_val     = 8'($urandom);
`endif
      step();
    end
    s_if.tvalid = 1'b0;
    wait_idle();

`ifdef AXIS_GPIO_WRITER_READBACK_EN
    // Readback: pulled pins merge with driven ones in the reported value.
    repeat (3) step();
    ext_val     = 8'h5A;
    cfg_hold    = 16'd4;
    s_if.tvalid = 1'b1;
    s_if.tdata  = {8'hF0, 8'hC0};
    step();
    s_if.tvalid = 1'b0;
    pulses  = 0;
    rb_data = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) begin
        pulses++;
        rb_data = m_axis_tdata;
      end
    end
    chk("rb_pulses", 32'(pulses), 32'd1);
    chk("rb_value", 32'(rb_data), 32'hCA);
    step();
    cfg_hold    = 16'd0;
    s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      if (m_axis_tvalid) pulses++;
    end
    chk("rb_h0_pulses", 32'(pulses), 32'd0);
`else
    pulses  = 0;
    rb_data = '0;
`endif

    repeat (2) step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
